cuppa_wvb_hdr_fifo: RTL and testbench
=====================================

Name: cuppa_wvb_hdr_fifo

Overview:
Parametrised successor to the waveform-buffer header bundler: packs per-trigger header fields into one bundle word and tags it with a running event sequence number. The word is stored in a small header FIFO. It sits between the waveform-buffer write controller, which pushes one header per captured waveform, and the readout engine, which pops headers with a valid/read handshake. Field widths and FIFO depth are generic, and overflow is detected and counted.

Parameters:
LTC_W, 48, width of evt_ltc timestamp field
ADDR_W, 15, width of start_addr / stop_addr (waveform buffer address)
TRIG_W, 2, width of trig_src
PRE_CONF_W, 6, width of pre_conf
EVT_CNT_W, 16, width of event sequence number field
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries
DROP_CNT_W, 8, width of saturating dropped-header counter
HDR_W (derived, not overridable), LTC_W+2*ADDR_W+TRIG_W+1+PRE_CONF_W+EVT_CNT_W; 103 at defaults

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hdr_wr  in  1  push strobe, one header per cycle when high
evt_ltc  in  LTC_W  event timestamp
start_addr  in  ADDR_W  waveform start address
stop_addr  in  ADDR_W  waveform stop address
trig_src  in  TRIG_W  trigger source code
cnst_run  in  1  constant-run flag
pre_conf  in  PRE_CONF_W  pretrigger configuration
hdr_rd  in  1  pop/acknowledge of the current output header
flush  in  1  synchronous FIFO clear
ovfl_clr  in  1  clears sticky overflow and drop_cnt
hdr_bundle  out  HDR_W  head-of-FIFO header word
hdr_valid  out  1  hdr_bundle holds a valid header
n_hdrs  out  DEPTH_LOG2+1  current occupancy
full  out  1  occupancy == 2**DEPTH_LOG2
overflow  out  1  sticky: a push was dropped
drop_cnt  out  DROP_CNT_W  number of dropped pushes, saturating

Behaviour:
- Packing, LSB first: evt_ltc [LTC_W-1:0], then start_addr, stop_addr, trig_src, cnst_run, pre_conf, evt_cnt at the top. At defaults: ltc[47:0], start[62:48], stop[77:63], trig[79:78], cnst[80], pre_conf[86:81], evt_cnt[102:87].
- evt_cnt is an internal EVT_CNT_W counter. An accepted push stores the pre-increment value, so the first header after reset carries 0. The counter then increments and wraps from 2**EVT_CNT_W-1 to 0. Dropped pushes do not increment it. Flush does not reset it.
- Pop is effective when hdr_rd && hdr_valid. hdr_rd while empty is ignored: no pointer movement and no error.
- Push is accepted when hdr_wr && (!full || pop effective). When full, a simultaneous push and pop both complete and occupancy stays at max.
- Push is dropped when hdr_wr && full && !pop. A drop sets overflow and increments drop_cnt, saturating at all-ones.
- Latency: an accepted push is visible on hdr_bundle/hdr_valid on the next cycle. This holds for an empty FIFO and for simultaneous push+pop at occupancy 1.
- hdr_bundle is first-word-fall-through and stays stable while hdr_valid && !hdr_rd. After a pop, the next entry appears on the following cycle. hdr_bundle is don't-care while hdr_valid is 0.
- Occupancy tracking:
  - n_hdrs updates +1 on push only, -1 on pop only, and is unchanged on both or neither.
  - full and hdr_valid (= n_hdrs != 0) are registered, consistent with n_hdrs.
  - Pointers wrap modulo 2**DEPTH_LOG2.
- flush has priority over push and pop in the same cycle. Next cycle: n_hdrs=0, hdr_valid=0, full=0. Storage contents are not cleared. overflow and drop_cnt are unaffected.
- ovfl_clr zeroes overflow and drop_cnt next cycle. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Reset (rst_n low, async) sets hdr_valid=0, n_hdrs=0, full=0, overflow=0, drop_cnt=0, evt_cnt=0 and both pointers to 0. hdr_bundle resets to 0. Reset mid-transfer discards all stored headers.
- Storage is inferred RAM/registers with no reset requirement on array contents.

Test Plan:
- Single push (evt_ltc=48'h0000_1234_5678, start=15'h0010, stop=15'h0200, trig=2'b10, cnst=1, pre_conf=6'h2A) -> next cycle hdr_valid=1, n_hdrs=1, each field at its packed offset, evt_cnt field=0. Pop -> hdr_valid=0 next cycle.
- 16 pushes with no pops (DEPTH_LOG2=4) -> full=1, n_hdrs=16. 17th push dropped: overflow=1, drop_cnt=1. Pop all 16 -> evt_cnt fields 0..15 in order, no corruption at pointer wrap.
- Full FIFO with push+pop in the same cycle -> n_hdrs stays 16, overflow stays 0, the pushed header carries evt_cnt=16 and emerges 16th in line.
- Push with no pop 300 times into a full FIFO -> drop_cnt saturates at 8'hFF. ovfl_clr concurrent with a drop -> overflow=1, drop_cnt=1. ovfl_clr alone -> both 0.
- EVT_CNT_W=4, 20 push/pop pairs -> evt_cnt field sequence 0..15,0..3. Flush with push in the same cycle -> empty next cycle, and the next accepted header carries the un-reset count.
- Assert rst_n low asynchronously mid-stream with n_hdrs=5 -> outputs zero immediately. After release, the first push yields evt_cnt=0 and n_hdrs=1.

Source files
------------

// File: rtl/cuppa_wvb_hdr_fifo.sv
// Packs per-trigger header fields plus a running event number into one word and queues it in a FWFT FIFO.
// Latency 1 cycle push-to-head; pushes into a full FIFO without a same-cycle pop are dropped and counted.
module cuppa_wvb_hdr_fifo #(
  parameter int LTC_W      = 48,
  parameter int ADDR_W     = 15,
  parameter int TRIG_W     = 2,
  parameter int PRE_CONF_W = 6,
  parameter int EVT_CNT_W  = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int DROP_CNT_W = 8,
  localparam int HDR_W     = LTC_W + 2*ADDR_W + TRIG_W + 1 + PRE_CONF_W + EVT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hdr_wr,
  input  logic [LTC_W-1:0]      evt_ltc,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     stop_addr,
  input  logic [TRIG_W-1:0]     trig_src,
  input  logic                  cnst_run,
  input  logic [PRE_CONF_W-1:0] pre_conf,
  input  logic                  hdr_rd,
  input  logic                  flush,
  input  logic                  ovfl_clr,
  output logic [HDR_W-1:0]      hdr_bundle,
  output logic                  hdr_valid,
  output logic [DEPTH_LOG2:0]   n_hdrs,
  output logic                  full,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [EVT_CNT_W-1:0]  EVT_ONE  = 1;
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = 1;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  logic [HDR_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   cnt_nxt;
  logic [EVT_CNT_W-1:0]  evt_cnt;
  logic [HDR_W-1:0]      wdat, head_nxt;
  logic                  pop, push, drop;

  assign wdat = {evt_cnt, pre_conf, cnst_run, trig_src, stop_addr, start_addr, evt_ltc};
  assign pop  = hdr_rd && hdr_valid && !flush;
  assign push = hdr_wr && !flush && (!full || pop);
  assign drop = hdr_wr && !flush && full && !pop;

  always_comb begin
    cnt_nxt    = n_hdrs;
    rd_ptr_nxt = rd_ptr;
    if (push && !pop) cnt_nxt = n_hdrs + CNT_ONE;
    if (pop && !push) cnt_nxt = n_hdrs - CNT_ONE;
    if (pop) rd_ptr_nxt = rd_ptr + PTR_ONE;
    // When the FIFO drains to empty this cycle the pushed word is the next head; bypass the array.
    if (push && (n_hdrs == '0 || (n_hdrs == CNT_ONE && pop)))
      head_nxt = wdat;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      n_hdrs     <= '0;
      hdr_valid  <= 1'b0;
      full       <= 1'b0;
      hdr_bundle <= '0;
      evt_cnt    <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      n_hdrs    <= '0;
      hdr_valid <= 1'b0;
      full      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        evt_cnt <= evt_cnt + EVT_ONE;
      end
      rd_ptr     <= rd_ptr_nxt;
      n_hdrs     <= cnt_nxt;
      hdr_valid  <= cnt_nxt != '0;
      full       <= cnt_nxt == CNT_FULL;
      hdr_bundle <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovfl_clr)              drop_cnt <= DROP_ONE;
      else if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_ONE;
    end else if (ovfl_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cuppa_wvb_hdr_fifo.sv
// Bench for cuppa_wvb_hdr_fifo: default instance plus a 4-bit event-counter instance on shared inputs,
// both checked against a queue-based reference model.
module tb_cuppa_wvb_hdr_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_wr = 1'b0, hdr_rd = 1'b0, flush = 1'b0, ovfl_clr = 1'b0, cnst_run = 1'b0;
  logic [47:0] evt_ltc = '0;
  logic [14:0] start_addr = '0, stop_addr = '0;
  logic [1:0]  trig_src = '0;
  logic [5:0]  pre_conf = '0;

  logic [102:0] hdr_bundle;
  logic         hdr_valid, full, overflow;
  logic [4:0]   n_hdrs;
  logic [7:0]   drop_cnt;
  logic [90:0]  hdr_bundle4;
  logic         hdr_valid4, full4, overflow4;
  logic [4:0]   n_hdrs4;
  logic [7:0]   drop_cnt4;

  always #5 clk = ~clk;

  cuppa_wvb_hdr_fifo u_dut (
    .clk(clk), .rst_n(rst_n), .hdr_wr(hdr_wr), .evt_ltc(evt_ltc), .start_addr(start_addr),
    .stop_addr(stop_addr), .trig_src(trig_src), .cnst_run(cnst_run), .pre_conf(pre_conf),
    .hdr_rd(hdr_rd), .flush(flush), .ovfl_clr(ovfl_clr), .hdr_bundle(hdr_bundle),
    .hdr_valid(hdr_valid), .n_hdrs(n_hdrs), .full(full), .overflow(overflow), .drop_cnt(drop_cnt));

  cuppa_wvb_hdr_fifo #(.EVT_CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .hdr_wr(hdr_wr), .evt_ltc(evt_ltc), .start_addr(start_addr),
    .stop_addr(stop_addr), .trig_src(trig_src), .cnst_run(cnst_run), .pre_conf(pre_conf),
    .hdr_rd(hdr_rd), .flush(flush), .ovfl_clr(ovfl_clr), .hdr_bundle(hdr_bundle4),
    .hdr_valid(hdr_valid4), .n_hdrs(n_hdrs4), .full(full4), .overflow(overflow4), .drop_cnt(drop_cnt4));

  typedef struct {
    logic [47:0] ltc;
    logic [14:0] sa, sp;
    logic [1:0]  tr;
    logic        cn;
    logic [5:0]  pc;
    int unsigned cnt;
  } ent_t;

  ent_t        q[$];
  int unsigned ecnt;
  bit          m_ovf;
  int          m_dc;
  int          chk = 0;
  int          err = 0;

  function automatic logic [102:0] pk(ent_t e);
    logic [15:0] c = e.cnt[15:0];
    return {c, e.pc, e.cn, e.tr, e.sp, e.sa, e.ltc};
  endfunction

  function automatic logic [90:0] pk4(ent_t e);
    logic [3:0] c = e.cnt[3:0];
    return {c, e.pc, e.cn, e.tr, e.sp, e.sa, e.ltc};
  endfunction

  task automatic rand_fields();
    evt_ltc    = {16'($urandom), $urandom};
    start_addr = 15'($urandom);
    stop_addr  = 15'($urandom);
    trig_src   = 2'($urandom);
    cnst_run   = 1'($urandom);
    pre_conf   = 6'($urandom);
  endtask

  task automatic model_clear();
    q.delete();
    ecnt  = 0;
    m_ovf = 0;
    m_dc  = 0;
  endtask

  // Apply one cycle of stimulus, advance the model, then return 1 time unit after the clock edge.
  task automatic step(input bit wr, input bit rd, input bit fl, input bit oc);
    ent_t cur, tmp;
    bit   pop, acc, drp, fullm;
    hdr_wr = wr; hdr_rd = rd; flush = fl; ovfl_clr = oc;
    cur.ltc = evt_ltc; cur.sa = start_addr; cur.sp = stop_addr;
    cur.tr = trig_src; cur.cn = cnst_run; cur.pc = pre_conf; cur.cnt = ecnt;
    drp = 0;
    if (fl) q.delete();
    else begin
      pop   = rd && q.size() > 0;
      fullm = q.size() == 16;
      acc   = wr && (!fullm || pop);
      drp   = wr && fullm && !pop;
      if (pop) tmp = q.pop_front();
      if (acc) begin q.push_back(cur); ecnt++; end
    end
    if (drp) begin
      m_ovf = 1;
      m_dc  = oc ? 1 : (m_dc == 255 ? 255 : m_dc + 1);
    end else if (oc) begin
      m_ovf = 0;
      m_dc  = 0;
    end
    @(posedge clk); #1;
    hdr_wr = 0; hdr_rd = 0; flush = 0; ovfl_clr = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    hdr_wr = 0; hdr_rd = 0; flush = 0; ovfl_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    chk++;
    if (hdr_valid !== 1'b0 || n_hdrs !== 5'd0 || full !== 1'b0 || overflow !== 1'b0 ||
        drop_cnt !== 8'd0 || hdr_bundle !== 103'd0) begin
      err++;
      $display("FAIL reset: valid=%b n=%0d full=%b ovf=%b drop=%0d bundle=%h, required all zero",
               hdr_valid, n_hdrs, full, overflow, drop_cnt, hdr_bundle);
    end
    apply_reset();
  endtask

  task automatic test_single_push();
    apply_reset();
    evt_ltc = 48'h0000_1234_5678; start_addr = 15'h0010; stop_addr = 15'h0200;
    trig_src = 2'b10; cnst_run = 1'b1; pre_conf = 6'h2A;
    step(1, 0, 0, 0);
    chk++;
    if (hdr_valid !== 1'b1 || n_hdrs !== 5'd1) begin
      err++; $display("FAIL single_occ: valid=%b n=%0d, required 1 1", hdr_valid, n_hdrs);
    end
    chk++;
    if (hdr_bundle[47:0] !== 48'h0000_1234_5678 || hdr_bundle[62:48] !== 15'h0010 ||
        hdr_bundle[77:63] !== 15'h0200 || hdr_bundle[79:78] !== 2'b10 || hdr_bundle[80] !== 1'b1 ||
        hdr_bundle[86:81] !== 6'h2A || hdr_bundle[102:87] !== 16'd0) begin
      err++; $display("FAIL single_fields: bundle=%h, required %h", hdr_bundle,
                      {16'd0, 6'h2A, 1'b1, 2'b10, 15'h0200, 15'h0010, 48'h0000_1234_5678});
    end
    step(0, 1, 0, 0);
    chk++;
    if (hdr_valid !== 1'b0 || n_hdrs !== 5'd0) begin
      err++; $display("FAIL single_pop: valid=%b n=%0d, required 0 0", hdr_valid, n_hdrs);
    end
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      rand_fields();
      step(1, 0, 0, 0);
    end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    fill16();
    chk++;
    if (full !== 1'b1 || n_hdrs !== 5'd16 || overflow !== 1'b0) begin
      err++; $display("FAIL fill_full: full=%b n=%0d ovf=%b, required 1 16 0", full, n_hdrs, overflow);
    end
    rand_fields();
    step(1, 0, 0, 0);
    chk++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1 || n_hdrs !== 5'd16) begin
      err++; $display("FAIL fill_drop: ovf=%b drop=%0d n=%0d, required 1 1 16", overflow, drop_cnt, n_hdrs);
    end
    for (int i = 0; i < 16; i++) begin
      chk++;
      if (hdr_valid !== 1'b1 || hdr_bundle[102:87] !== 16'(i) || hdr_bundle !== pk(q[0])) begin
        err++; $display("FAIL fill_drain[%0d]: valid=%b bundle=%h, required %h", i, hdr_valid, hdr_bundle, pk(q[0]));
      end
      step(0, 1, 0, 0);
    end
    chk++;
    if (hdr_valid !== 1'b0 || n_hdrs !== 5'd0 || full !== 1'b0) begin
      err++; $display("FAIL fill_empty: valid=%b n=%0d full=%b, required 0 0 0", hdr_valid, n_hdrs, full);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    fill16();
    rand_fields();
    step(1, 1, 0, 0);
    chk++;
    if (n_hdrs !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      err++; $display("FAIL fpp_occ: n=%0d full=%b ovf=%b, required 16 1 0", n_hdrs, full, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      chk++;
      if (hdr_bundle[102:87] !== 16'(i + 1) || hdr_bundle !== pk(q[0])) begin
        err++; $display("FAIL fpp_drain[%0d]: bundle=%h, required %h (evt %0d)", i, hdr_bundle, pk(q[0]), i + 1);
      end
      step(0, 1, 0, 0);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    fill16();
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0);
    chk++;
    if (drop_cnt !== 8'hFF || overflow !== 1'b1) begin
      err++; $display("FAIL sat: drop=%0d ovf=%b, required 255 1", drop_cnt, overflow);
    end
    step(1, 0, 0, 1);
    chk++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
      err++; $display("FAIL clr_vs_drop: drop=%0d ovf=%b, required 1 1", drop_cnt, overflow);
    end
    step(0, 0, 0, 1);
    chk++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0 || n_hdrs !== 5'd16) begin
      err++; $display("FAIL clr: drop=%0d ovf=%b n=%0d, required 0 0 16", drop_cnt, overflow, n_hdrs);
    end
  endtask

  task automatic test_wrap_flush();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      rand_fields();
      step(1, 1, 0, 0);
      chk++;
      if (hdr_valid4 !== 1'b1 || n_hdrs4 !== 5'd1 || hdr_bundle4[90:87] !== 4'(i % 16) || hdr_bundle4 !== pk4(q[0])) begin
        err++; $display("FAIL wrap4[%0d]: n=%0d bundle=%h, required 1 %h", i, n_hdrs4, hdr_bundle4, pk4(q[0]));
      end
    end
    rand_fields();
    step(1, 0, 1, 0);
    chk++;
    if (n_hdrs !== 5'd0 || hdr_valid !== 1'b0 || full !== 1'b0 || n_hdrs4 !== 5'd0 || hdr_valid4 !== 1'b0) begin
      err++; $display("FAIL flush: n=%0d valid=%b full=%b n4=%0d, required 0 0 0 0", n_hdrs, hdr_valid, full, n_hdrs4);
    end
    rand_fields();
    step(1, 0, 0, 0);
    chk++;
    if (hdr_bundle[102:87] !== 16'd20 || hdr_bundle4[90:87] !== 4'd4 || n_hdrs !== 5'd1) begin
      err++; $display("FAIL post_flush: evt=%0d evt4=%0d n=%0d, required 20 4 1",
                      hdr_bundle[102:87], hdr_bundle4[90:87], n_hdrs);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      int pw = (i < 500) ? 75 : 45;
      rand_fields();
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
      chk++;
      if (n_hdrs !== 5'(q.size()) || hdr_valid !== (q.size() != 0) || full !== (q.size() == 16) ||
          overflow !== m_ovf || drop_cnt !== 8'(m_dc) || n_hdrs4 !== 5'(q.size()) ||
          (q.size() != 0 && (hdr_bundle !== pk(q[0]) || hdr_bundle4 !== pk4(q[0])))) begin
        err++;
        if (bad++ < 10)
          $display("FAIL random[%0d]: n=%0d valid=%b full=%b ovf=%b drop=%0d, required n=%0d ovf=%b drop=%0d",
                   i, n_hdrs, hdr_valid, full, overflow, drop_cnt, q.size(), m_ovf, m_dc);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin rand_fields(); step(1, 0, 0, 0); end
    chk++;
    if (n_hdrs !== 5'd5) begin
      err++; $display("FAIL pre_arst: n=%0d, required 5", n_hdrs);
    end
    #2 rst_n = 0;
    #1;
    chk++;
    if (hdr_valid !== 1'b0 || n_hdrs !== 5'd0 || full !== 1'b0 || hdr_bundle !== 103'd0) begin
      err++; $display("FAIL arst: valid=%b n=%0d full=%b bundle=%h, required all zero", hdr_valid, n_hdrs, full, hdr_bundle);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1;
    rand_fields();
    step(1, 0, 0, 0);
    chk++;
    if (n_hdrs !== 5'd1 || hdr_valid !== 1'b1 || hdr_bundle[102:87] !== 16'd0 || hdr_bundle !== pk(q[0])) begin
      err++; $display("FAIL post_arst: n=%0d evt=%0d, required 1 0", n_hdrs, hdr_bundle[102:87]);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_push_pop();
    test_saturate();
    test_wrap_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
